// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential binary32 divider, radix-2 restoring, one quotient bit per cycle.
// Denormals flush to zero, exp==255 is infinity, 27-edge latency from accept to valid.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        ready,
    output logic        valid,
    output logic [31:0] z,
    output logic [5:0]  status
);
    typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;
    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d, sz_q, sz_d;
    logic [2:0]         rnd_q, rnd_d;
    logic [5:0]         status_q, status_d;
    logic               ready_q, ready_d, valid_q, valid_d;
    logic               sign_q, sign_d, spec_q, spec_d, snan_q, snan_d;
    logic signed [9:0]  e_q, e_d;
    logic [25:0]        r_q, r_d;
    logic [23:0]        mb_q, mb_d;
    logic [24:0]        q_q, q_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [7:0]         ea, eb;
    logic               za, zb, ia, ib, lt, nan_c, inf_c, zero_c;
    logic [23:0]        ma, mb;
    logic [25:0]        t;
    logic               qb, g, s, lsb, inc, huge, tiny, ovf_inf, unf_min;
    logic [2:0]         m;
    logic [24:0]        sig;
    logic signed [9:0]  er;
    logic [31:0]        zr;
    always_comb begin
        ea      = a_q[30:23];
        eb      = b_q[30:23];
        za      = ea == 8'd0;
        zb      = eb == 8'd0;
        ia      = ea == 8'hFF;
        ib      = eb == 8'hFF;
        ma      = {1'b1, a_q[22:0]};
        mb      = {1'b1, b_q[22:0]};
        lt      = ma < mb;
        nan_c   = (za & zb) | (ia & ib);
        inf_c   = ia | (~za & zb);
        zero_c  = za | ib;
        t       = r_q - {2'b0, mb_q};
        qb      = ~t[25];
        g       = q_q[0];
        lsb     = q_q[1];
        s       = |r_q;
        // Reserved modes 110/111 behave as round-to-nearest-even
        m       = (rnd_q[2:1] == 2'b11) ? 3'd0 : rnd_q;
        inc     = (m == 3'd0) ? g & (lsb | s) :
                  (m == 3'd1) ? 1'b0 :
                  (m == 3'd2) ? ~sign_q & (g | s) :
                  (m == 3'd3) ? sign_q & (g | s) :
                  (m == 3'd4) ? g & (s | ~sign_q) : (g | s);
        sig     = {2'b01, q_q[23:1]} + {24'd0, inc};
        er      = e_q + {9'd0, sig[24]};
        huge    = er >= 10'sd255;
        tiny    = er <= 10'sd0;
        ovf_inf = (m == 3'd0) | (m == 3'd4) | (m == 3'd5) | ((m == 3'd2) & ~sign_q) | ((m == 3'd3) & sign_q);
        unf_min = (m == 3'd5) | ((m == 3'd2) & ~sign_q) | ((m == 3'd3) & sign_q);
        zr      = spec_q ? sz_q :
                  huge   ? (ovf_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'h7F7FFFFF}) :
                  tiny   ? (unf_min ? {sign_q, 31'h00800000} : {sign_q, 31'd0}) :
                           {sign_q, er[7:0], sig[22:0]};
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rnd_d    = rnd_q;
        z_d      = z_q;
        status_d = status_q;
        ready_d  = ready_q;
        valid_d  = 1'b0;
        sign_d   = sign_q;
        spec_d   = spec_q;
        snan_d   = snan_q;
        sz_d     = sz_q;
        e_d      = e_q;
        r_d      = r_q;
        mb_d     = mb_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                rnd_d   = rnd;
                ready_d = 1'b0;
                state_d = UNPACK;
            end
            UNPACK: begin
                sign_d  = a_q[31] ^ b_q[31];
                spec_d  = nan_c | inf_c | zero_c;
                snan_d  = nan_c;
                sz_d    = nan_c ? 32'h7F800000 : inf_c ? {sign_d, 8'hFF, 23'd0} : {sign_d, 31'd0};
                e_d     = $signed({2'b0, ea}) - $signed({2'b0, eb}) + 10'sd127 - $signed({9'd0, lt});
                // Pre-normalise so the quotient lands in [1,2)
                r_d     = lt ? {1'b0, ma, 1'b0} : {2'b0, ma};
                mb_d    = mb;
                q_d     = 25'd0;
                cnt_d   = 5'd0;
                state_d = DIVIDE;
            end
            DIVIDE: begin
                r_d     = (qb ? t : r_q) << 1;
                q_d     = {q_q[23:0], qb};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd24) ? ROUND : DIVIDE;
            end
            default: begin
                z_d      = zr;
                status_d = {~spec_q & (g | s | huge | tiny), ~spec_q & huge, ~spec_q & tiny,
                            spec_q & snan_q, &zr[30:23], ~|zr[30:0]};
                valid_d  = 1'b1;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rnd_q    <= '0;
            z_q      <= '0;
            status_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sign_q   <= 1'b0;
            spec_q   <= 1'b0;
            snan_q   <= 1'b0;
            sz_q     <= '0;
            e_q      <= '0;
            r_q      <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rnd_q    <= rnd_d;
            z_q      <= z_d;
            status_q <= status_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            sign_q   <= sign_d;
            spec_q   <= spec_d;
            snan_q   <= snan_d;
            sz_q     <= sz_d;
            e_q      <= e_d;
            r_q      <= r_d;
            mb_q     <= mb_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
        end
    end
    assign ready  = ready_q;
    assign valid  = valid_q;
    assign z      = z_q;
    assign status = status_q;
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE-754 binary32 divider, z = a / b; the inverse-operation companion to the team's fp multiplier.
- Shares the multiplier's conventions: rounding-mode set, denormal flush-to-zero, exponent-all-ones treated as infinity, canonical special results.
- Radix-2 restoring division, one quotient bit per cycle, behind a start/ready/valid handshake with constant latency.
- Sits beside the multiplier in the FP datapath and is checked against the same style of golden reference.

Parameters:
- none; all widths are fixed by the binary32 format.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when ready=1.
- a  in  32  dividend, binary32.
- b  in  32  divisor, binary32.
- rnd  in  3  rounding mode, latched with operands: 000 IEEE_near, 001 IEEE_zero, 010 IEEE_pinf, 011 IEEE_ninf, 100 near_up, 101 away_zero; 110/111 treated as IEEE_near.
- ready  out  1  idle, able to accept.
- valid  out  1  one-cycle pulse, z/status valid.
- z  out  32  result; held until the next valid.
- status  out  6  {inexact, huge, tiny, nan, inf, zero}; held with z.

Behaviour:
- Reset (rst=0, any time, including mid-operation): abort the operation; state=IDLE; ready=1, valid=0, z=0, status=0.
- States: IDLE -> UNPACK -> DIVIDE -> ROUND -> IDLE.
- Accept: start=1 and ready=1 at an edge latches a, b, rnd; ready drops to 0 next cycle. start while busy is ignored, never queued.
- UNPACK (1 cycle):
  - exp==0 forces that operand to signed zero (flush); exp==255 makes it infinity with mantissa ignored.
  - sign = sa^sb; e = ea - eb + 127, 10-bit signed.
  - ma = {1,fa}, mb = {1,fb}; if ma<mb then ma<<=1 and e -= 1, so the quotient lies in [1,2).
- DIVIDE (25 cycles): per cycle, r' = 2r - mb if non-negative, else 2r; emits 24 significand bits plus a guard bit g. Sticky s = (final remainder != 0).
- ROUND (1 cycle), inc rule (lsb = quotient bit 0):
  - near: g&(lsb|s)
  - zero: 0
  - pinf: ~sign&(g|s)
  - ninf: sign&(g|s)
  - near_up: g&(s|~sign), so ties go toward +inf
  - away: g|s
  - Significand carry-out sets mantissa=0 and e += 1. inexact = g|s.
- Overflow (e>=255 after rounding), huge=1, inexact=1:
  - near/near_up/away: signed inf.
  - zero: signed 0x7F7FFFFF (max normal).
  - pinf: +inf if positive, else 0xFF7FFFFF.
  - ninf: -inf if negative, else 0x7F7FFFFF.
- Underflow (e<=0), tiny=1, inexact=1, no denormal outputs:
  - near/zero/near_up: signed zero.
  - away: signed min normal 0x00800000.
  - pinf: positive -> 0x00800000, negative -> 0x80000000.
  - ninf: negative -> 0x80800000, positive -> 0x00000000.
- Specials (decided in UNPACK, same total latency):
  - 0/0 or inf/inf: z=0x7F800000, nan=1, inf=1.
  - x/0 (x nonzero finite) or inf/finite: z = signed inf, inf=1.
  - 0/x or finite/inf: z = signed zero, zero=1.
- zero flag = (z[30:0]==0); inf flag = (z[30:23]==255).
- Latency: valid is high in the cycle after the 27th rising edge following the accepting edge, for exactly one cycle. ready returns to 1 in that same cycle, so back-to-back start is accepted on the next edge.

Test Plan:
- Basic divide: a=0x40C00000, b=0x40000000, rnd=000 -> z=0x40400000, status=0, valid exactly 27 edges after accept, ready=0 throughout.
- Rounding, positive: a=0x3F800000, b=0x40400000 -> near/pinf/away/near_up give 0x3EAAAAAB; zero/ninf give 0x3EAAAAAA; inexact=1.
- Rounding, negative: a=0xBF800000, b=0x40400000 -> pinf/zero give 0xBEAAAAAA; ninf/near/away give 0xBEAAAAAB.
- Specials:
  - 0x40A00000/0 -> 0x7F800000, inf=1.
  - 0/0 -> 0x7F800000, nan=1.
  - 0x00000001/0x3F800000 -> 0x00000000, zero=1.
  - 0x3F800000/0xFF800000 -> 0x80000000.
- Range:
  - 0x7F7FFFFF/0x3F000000: near -> 0x7F800000, huge=1; zero -> 0x7F7FFFFF.
  - 0x00800000/0x40000000: near -> 0x00000000, tiny=1; away -> 0x00800000.
- Handshake and reset:
  - start held high for 60 cycles -> exactly two results, accepted back-to-back.
  - rst pulsed low in DIVIDE cycle 10 -> valid never fires, z=0, ready=1 after release, and the next op is correct.
